blink_controller: RTL

- Sequencer and scheduler for a bank of blink channels that share one free-running 16-bit count.
- Owns the count and holds per-channel configuration: mode, rate bit, phase offset and burst length.
- Produces each channel's blink level, the same level the blinker datapath would give for count + offset.
- Configuration arrives over a valid/ready port and is committed only on a count boundary, so outputs never glitch mid-period.

---
 rtl/blink_pkg.sv | 30 +++
 rtl/blink_channel.sv | 120 ++++++++++++
 rtl/blink_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the blink controller and its per-channel datapath.
// Holds the mode encoding, the control FSM state type and the packed
// channel-configuration payload carried from the shadow register to a channel.
// Optional feature macro: BLINK_CONTROLLER_INVERT_EN (per-channel output invert).
package blink_pkg;

    localparam int unsigned CH_CNT_W   = 16;
    localparam int unsigned CH_BURST_W = 4;
    localparam int unsigned MODE_W     = 2;
    localparam int unsigned RATE_W     = 4;

    localparam logic [MODE_W-1:0] MODE_OFF   = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_ON    = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_BLINK = MODE_W'(2);
    localparam logic [MODE_W-1:0] MODE_BURST = MODE_W'(3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        COMMIT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic [MODE_W-1:0]     mode;
        logic [RATE_W-1:0]     rate;
        logic [CH_CNT_W-1:0]   offset;
        logic [CH_BURST_W-1:0] burst;
    } ch_cfg_t;

endpackage

// File: rtl/blink_channel.sv
// One blink channel: configuration registers, phase-offset add, rate bit
// select, rising-edge detector with burst counter, and the registered output.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   count         shared free-running count
//   wr            load cfg this cycle (commit strobe for this channel)
//   cfg           configuration payload
//   invert        output invert, loaded with cfg (BLINK_CONTROLLER_INVERT_EN only)
//   blink         registered blink level
//   burst_done    sticky burst-finished flag
module blink_channel
    import blink_pkg::*;
#(
    parameter int unsigned CNT_W   = CH_CNT_W,
    parameter int unsigned BURST_W = CH_BURST_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count,
    input  logic             wr,
    input  ch_cfg_t          cfg,
`ifdef BLINK_CONTROLLER_INVERT_EN
    input  logic             invert,
`endif
    output logic             blink,
    output logic             burst_done
);
    localparam int unsigned IDX_W = $clog2(CNT_W);

    ch_cfg_t            cfg_q;
    logic [BURST_W-1:0] burst_cnt;
    logic               lvl_prev;
    logic               hold;
    logic               blink_q;
    logic               done_q;
    logic               inv;

    logic [CNT_W-1:0]   sh;
    logic [IDX_W-1:0]   idx;
    logic               lvl;
    logic               rise;
    logic               gate;
    logic               level;

    assign blink      = blink_q;
    assign burst_done = done_q;

    // Level generation; gate keeps a whole high period once its rising edge was allowed.
    always_comb begin
        sh    = count + cfg_q.offset;
        idx   = IDX_W'(CNT_W - 1);
        lvl   = 1'b0;
        rise  = 1'b0;
        gate  = 1'b0;
        level = 1'b0;
        if (32'(cfg_q.rate) <= CNT_W - 1) begin
            idx = IDX_W'(cfg_q.rate);
        end
        lvl  = sh[idx];
        rise = lvl & ~lvl_prev;
        if (rise) begin
            gate = (burst_cnt < cfg_q.burst);
        end else if (lvl) begin
            gate = hold;
        end
        case (cfg_q.mode)
            MODE_ON:    level = 1'b1;
            MODE_BLINK: level = lvl;
            MODE_BURST: level = lvl & gate;
            default:    level = 1'b0;
        endcase
    end

`ifdef BLINK_CONTROLLER_INVERT_EN
    // Invert register, loaded together with the rest of the configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv <= 1'b0;
        end else if (wr) begin
            inv <= invert;
        end
    end
`else
    assign inv = 1'b0;
`endif

    // Config load, burst tracking and output register; a commit beats any burst edge.
    // lvl_prev is forced high on commit so a level already high is not counted as a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q     <= '0;
            burst_cnt <= '0;
            lvl_prev  <= 1'b0;
            hold      <= 1'b0;
            done_q    <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            blink_q <= level ^ inv;
            if (wr) begin
                cfg_q     <= cfg;
                burst_cnt <= '0;
                hold      <= 1'b0;
                lvl_prev  <= 1'b1;
                done_q    <= (cfg.mode == MODE_BURST) && (cfg.burst == '0);
            end else begin
                lvl_prev <= lvl;
                hold     <= gate;
                if (cfg_q.mode == MODE_BURST) begin
                    if (rise && gate) begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                    if (!lvl && (burst_cnt == cfg_q.burst)) begin
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/blink_controller.sv
// Blink controller top: shared free-running count, configuration handshake
// FSM with shadow register, and NUM_CH blink_channel instances.
// Configuration is committed only on a count boundary (or immediately when
// the count is frozen) so channel outputs never change mid-period.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   enable               count advances while high
//   cfg_valid/cfg_ready  configuration handshake
//   cfg_ch, cfg_mode, cfg_rate, cfg_offset, cfg_burst  configuration payload
//   cfg_invert           per-channel output invert (BLINK_CONTROLLER_INVERT_EN only)
//   count_out            shared count
//   blink_out            per-channel registered blink level
//   burst_done           per-channel sticky burst-finished flag
module blink_controller
    import blink_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = CH_CNT_W,
    parameter int unsigned COMMIT_BIT = 8,
    parameter int unsigned BURST_W    = CH_BURST_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [MODE_W-1:0]         cfg_mode,
    input  logic [RATE_W-1:0]         cfg_rate,
    input  logic [CNT_W-1:0]          cfg_offset,
    input  logic [BURST_W-1:0]        cfg_burst,
`ifdef BLINK_CONTROLLER_INVERT_EN
    input  logic                      cfg_invert,
`endif
    output logic [CNT_W-1:0]          count_out,
    output logic [NUM_CH-1:0]         blink_out,
    output logic [NUM_CH-1:0]         burst_done
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    ctrl_state_t     state;
    ctrl_state_t     state_next;
    logic            ready;
    logic [CNT_W-1:0] count;
    ch_cfg_t         shadow;
    logic [CH_W-1:0] shadow_ch;
    logic            shadow_inv;
    logic            accept;
    logic            commit;

    assign count_out = count;
    assign cfg_ready = ready;

    // Shared free-running count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Control FSM state register; ready mirrors the next state being IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
        end else begin
            state <= state_next;
            ready <= (state_next == IDLE);
        end
    end

    // Next-state logic; PEND waits for a boundary unless the count is frozen.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    accept     = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if ((count[COMMIT_BIT-1:0] == '0) || !enable) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow register captures the request on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            shadow_ch  <= '0;
            shadow_inv <= 1'b0;
        end else if (accept) begin
            shadow.mode   <= cfg_mode;
            shadow.rate   <= cfg_rate;
            shadow.offset <= cfg_offset;
            shadow.burst  <= cfg_burst;
            shadow_ch     <= cfg_ch;
`ifdef BLINK_CONTROLLER_INVERT_EN
            shadow_inv    <= cfg_invert;
`endif
        end
    end

    // Channel bank; an out-of-range shadow_ch matches no channel and writes nothing.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = commit && (shadow_ch == CH_W'(i));

        blink_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .count      (count),
            .wr         (wr),
            .cfg        (shadow),
`ifdef BLINK_CONTROLLER_INVERT_EN
            .invert     (shadow_inv),
`endif
            .blink      (blink_out[i]),
            .burst_done (burst_done[i])
        );
    end

`ifndef BLINK_CONTROLLER_INVERT_EN
    logic unused_inv;
    assign unused_inv = shadow_inv;
`endif

endmodule
